// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation at a time through a start/ready handshake; valid_o pulses for one
// cycle when result_o carries the quotient or remainder.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow complete
// straight from IDLE (valid_o in cycle 1) instead of iterating.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             is_signed;
  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes, the per-iteration trial subtraction and the sign fix-up.
  // The dividend register doubles as the quotient register: each iteration
  // shifts a dividend bit out of the top and a quotient bit in at the bottom.
  // A zero divisor makes every trial non-negative, so the quotient comes out all
  // ones and the remainder equals the dividend magnitude without special casing.
  assign is_signed    = ~op_i[0];
  assign abs_dividend = (is_signed && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign abs_divisor  = (is_signed && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
  assign shifted      = {rem_q, dvd_q[WIDTH-1]};
  assign trial        = shifted - {1'b0, dvs_q};
  assign quo_fix      = neg_quo_q ? -dvd_q : dvd_q;
  assign rem_fix      = neg_rem_q ? -rem_q : rem_q;

  // Next-state and datapath control; flush aborts anything in flight and
  // overrides a start in IDLE.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          op_d      = op_i;
          neg_quo_d = is_signed && (divisor_i != '0) &&
                      (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
          neg_rem_d = is_signed && dividend_i[WIDTH-1];
          dvd_d     = abs_dividend;
          dvs_d     = abs_divisor;
          rem_d     = '0;
          cnt_d     = CW'(WIDTH - 1);
          state_d   = CALC;
`ifdef DIV_FASTPATH_EN
          if (divisor_i == '0) begin
            result_d = op_i[1] ? dividend_i : '1;
            state_d  = DONE;
          end else if (is_signed && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (divisor_i == '1)) begin
            result_d = op_i[1] ? '0 : dividend_i;
            state_d  = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          result_d = op_q[1] ? rem_fix : quo_fix;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule
